iru_ctrl_unit_fp: RTL and testbench
===================================

Name: iru_ctrl_unit_fp

Overview:
Control unit at the input of the image rotation unit (IRU). It is the receiving end of the RDN-to-IRU handshake.
- Detects the RDN output-ready level and returns the `iru_in_ready` acknowledge pulse.
- Tells the datapath to capture the sub-image and angle, then sequences the rotation datapath.
- Streams the rotated sub-image pixel by pixel to the downstream BCAU stage over a valid/ready interface.

Parameters:
- NUM_PIXELS, 400, pixels per sub-image (20x20); must be >= 2.
- IDX_W, $clog2(NUM_PIXELS), width of the pixel index.

Ports:
- clk  input  1  system clock
- rst_n  input  1  asynchronous active-low reset
- rdn_out_ready  input  1  RDN has a finished sub-image and holds its data until acknowledged
- iru_in_ready  output  1  one-cycle acknowledge to RDN; sub-image is transferred in this cycle
- capture_en  output  1  datapath latches the RDN sub-image and angle
- start_rot  output  1  one-cycle start pulse to the rotation datapath
- rot_done  input  1  rotation datapath finished (pulse or level)
- out_valid  output  1  pixel at `pix_idx` is valid for BCAU
- bcau_in_ready  input  1  BCAU accepts the pixel
- pix_idx  output  IDX_W  index of the pixel being output; drives the datapath read mux
- out_last  output  1  current beat is the final pixel
- busy  output  1  unit is not in IDLE

Behaviour:
- Clocking and reset: one clock `clk`; reset `rst_n` is asynchronous and active-low.
  - On reset: state = IDLE, `pix_idx` = 0.
  - All outputs = 0.
  - Reset mid-operation abandons the frame; no partial output.
- FSM states (3-bit enum): IDLE, ACCEPT, ROT_START, ROT_WAIT, STREAM.
- IDLE:
  - `busy` = 0.
  - If `rdn_out_ready` = 1, next state = ACCEPT; otherwise stay.
- ACCEPT (exactly 1 cycle):
  - `iru_in_ready` = 1 and `capture_en` = 1.
  - RDN sees the acknowledge this cycle and releases its data, so the capture must happen here.
  - Next state = ROT_START unconditionally.
- ROT_START (1 cycle):
  - `start_rot` = 1.
  - `rot_done` is ignored in this cycle.
  - Next state = ROT_WAIT.
- ROT_WAIT:
  - Wait for `rot_done` = 1, then go to STREAM with `pix_idx` = 0.
  - No timeout.
- STREAM:
  - `out_valid` = 1.
  - A handshake is `out_valid` && `bcau_in_ready`.
  - On a handshake with `pix_idx` < NUM_PIXELS-1: `pix_idx` increments.
  - On a handshake with `pix_idx` = NUM_PIXELS-1: `pix_idx` wraps to 0 and next state = IDLE.
  - With no handshake, `pix_idx` and `out_valid` hold; valid is never withdrawn.
  - `out_last` = `out_valid` && (`pix_idx` = NUM_PIXELS-1).
- Output registration: all outputs are Moore, decoded from registered state, except `out_last` (comb from state and index). There are no comb paths from inputs to outputs.
- Handshake with RDN:
  - `rdn_out_ready` is ignored in every state except IDLE, so exactly one acknowledge is issued per frame.
  - If `rdn_out_ready` is already high on return to IDLE, ACCEPT follows on the next cycle.
  - Acknowledge latency from `rdn_out_ready` rising in IDLE is 1 cycle.
- Simultaneous events: `rot_done` during ACCEPT or IDLE is ignored. `bcau_in_ready` outside STREAM has no effect.
- Throughput: frame-to-frame minimum 4 + NUM_PIXELS cycles plus rotation latency.

Decomposition:
- Package `iru_pkg`:
  - `iru_state_t` enum.
  - `IRU_NUM_PIXELS` = 400 default constant.
  - Index width function/constant, shared with the IRU datapath and BCAU.
- One natural sub-module: `iru_pix_counter`.
  - Inputs: clear, enable, NUM_PIXELS parameter.
  - Outputs: index and last flag.
  - Reused by the BCAU receive side.

Test Plan:
- Reset: assert `rst_n` = 0 mid-cycle → all outputs 0, `pix_idx` = 0 asynchronously; hold inputs high → no activity until release.
- Nominal frame:
  - `rdn_out_ready` high at cycle 0 → `iru_in_ready`/`capture_en` high in cycle 1 only.
  - `start_rot` in cycle 2; `rot_done` at cycle 5 → `out_valid` from cycle 6.
  - `bcau_in_ready` = 1 → 400 beats, `pix_idx` 0..399, `out_last` only on idx 399, `busy` = 0 at cycle 406.
- Backpressure: `bcau_in_ready` alternating 1/0 → `out_valid` stays high, `pix_idx` advances only on handshake, exactly 400 transfers in 800 cycles.
- Stray RDN ready: hold `rdn_out_ready` = 1 throughout the frame → a single `iru_in_ready` pulse; the next pulse appears exactly 1 cycle after return to IDLE.
- Ignored `rot_done`:
  - `rot_done` high during ACCEPT and ROT_START → no STREAM entry until a later `rot_done`.
  - NUM_PIXELS = 4 variant: 4 beats, `out_last` on idx 3.
- Reset mid-stream at `pix_idx` = 123 → `out_valid` = 0 and `pix_idx` = 0 immediately; a new frame after release starts from idx 0.

Source files
------------

// File: rtl/iru_ctrl_unit_fp_pkg.sv
// Shared IRU definitions: control states and pixel-index sizing,
// used by the IRU control unit, its datapath and the BCAU side.
package iru_pkg;

    localparam int IRU_NUM_PIXELS = 400;

    typedef enum logic [2:0] {
        IDLE,
        ACCEPT,
        ROT_START,
        ROT_WAIT,
        STREAM
    } iru_state_t;

    function automatic int iru_idx_w(input int n);
        return (n < 2) ? 1 : $clog2(n);
    endfunction

    localparam int IRU_IDX_W = iru_idx_w(IRU_NUM_PIXELS);

endpackage

// File: rtl/iru_ctrl_unit_fp_if.sv
// Pixel stream from the IRU to BCAU: valid/ready plus index and last flag.
interface iru_ctrl_unit_fp_if #(
    parameter int IDX_W = 9
);
    logic             out_valid;
    logic             bcau_in_ready;
    logic [IDX_W-1:0] pix_idx;
    logic             out_last;

    modport master (
        output out_valid,
        output pix_idx,
        output out_last,
        input  bcau_in_ready
    );

    modport slave (
        input  out_valid,
        input  pix_idx,
        input  out_last,
        output bcau_in_ready
    );
endinterface

// File: rtl/iru_ctrl_unit_fp_pix_counter.sv
// Pixel index counter: wraps to zero after the last pixel of a sub-image.
module iru_pix_counter
    import iru_pkg::*;
#(
    parameter int NUM_PIXELS = IRU_NUM_PIXELS,
    parameter int IDX_W      = iru_idx_w(NUM_PIXELS)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             clear,
    input  logic             enable,
    output logic [IDX_W-1:0] idx,
    output logic             last
);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_PIXELS - 1);

    assign last = (idx == LAST_IDX);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            idx <= '0;
        end else if (clear) begin
            idx <= '0;
        end else if (enable) begin
            idx <= last ? '0 : idx + IDX_W'(1);
        end
    end
endmodule

// File: rtl/iru_ctrl_unit_fp.sv
// IRU input control: acknowledges RDN, starts the rotation and
// streams the rotated sub-image to BCAU one pixel per handshake.
module iru_ctrl_unit_fp
    import iru_pkg::*;
#(
    parameter int NUM_PIXELS = IRU_NUM_PIXELS,
    parameter int IDX_W      = iru_idx_w(NUM_PIXELS)
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               rdn_out_ready,
    output logic               iru_in_ready,
    output logic               capture_en,
    output logic               start_rot,
    input  logic               rot_done,
    output logic               busy,
    iru_ctrl_unit_fp_if.master bus
);
    iru_state_t       state;
    iru_state_t       state_nxt;
    logic             beat;
    logic             last;
    logic [IDX_W-1:0] idx;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    assign beat = (state == STREAM) && bus.bcau_in_ready;

    // RDN ready is only looked at in IDLE, so each frame gets one acknowledge.
    always_comb begin
        state_nxt = state;
        unique case (state)
            IDLE:      if (rdn_out_ready) state_nxt = ACCEPT;
            ACCEPT:    state_nxt = ROT_START;
            ROT_START: state_nxt = ROT_WAIT;
            ROT_WAIT:  if (rot_done) state_nxt = STREAM;
            STREAM:    if (beat && last) state_nxt = IDLE;
            default:   state_nxt = IDLE;
        endcase
    end

    // Held at zero outside STREAM so every frame starts from pixel 0.
    iru_pix_counter #(
        .NUM_PIXELS (NUM_PIXELS),
        .IDX_W      (IDX_W)
    ) u_cnt (
        .clk    (clk),
        .rst_n  (rst_n),
        .clear  (state != STREAM),
        .enable (beat),
        .idx    (idx),
        .last   (last)
    );

    assign iru_in_ready  = (state == ACCEPT);
    assign capture_en    = (state == ACCEPT);
    assign start_rot     = (state == ROT_START);
    assign busy          = (state != IDLE);
    assign bus.out_valid = (state == STREAM);
    assign bus.pix_idx   = idx;
    assign bus.out_last  = (state == STREAM) && last;
endmodule

// File: tb/tb_iru_ctrl_unit_fp.sv
// Bench for iru_ctrl_unit_fp: 400-pixel and 4-pixel instances share the
// same stimulus and are both checked against a frame-level model.
module tb_iru_ctrl_unit_fp;
    import iru_pkg::*;

    localparam int NA = 400;
    localparam int NB = 4;
    localparam int WA = iru_idx_w(NA);
    localparam int WB = iru_idx_w(NB);

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic rdn = 1'b0;
    logic rot_done = 1'b0;
    logic bcau = 1'b0;
    logic ack[2];
    logic cap[2];
    logic srt[2];
    logic bsy[2];
    int   nchk = 0;
    int   nerr = 0;

    iru_ctrl_unit_fp_if #(.IDX_W(WA)) bus_a ();
    iru_ctrl_unit_fp_if #(.IDX_W(WB)) bus_b ();

    assign bus_a.bcau_in_ready = bcau;
    assign bus_b.bcau_in_ready = bcau;

    always #5 clk = ~clk;

    iru_ctrl_unit_fp #(.NUM_PIXELS(NA)) dut_a (
        .clk           (clk),
        .rst_n         (rst_n),
        .rdn_out_ready (rdn),
        .iru_in_ready  (ack[0]),
        .capture_en    (cap[0]),
        .start_rot     (srt[0]),
        .rot_done      (rot_done),
        .busy          (bsy[0]),
        .bus           (bus_a)
    );

    iru_ctrl_unit_fp #(.NUM_PIXELS(NB)) dut_b (
        .clk           (clk),
        .rst_n         (rst_n),
        .rdn_out_ready (rdn),
        .iru_in_ready  (ack[1]),
        .capture_en    (cap[1]),
        .start_rot     (srt[1]),
        .rot_done      (rot_done),
        .busy          (bsy[1]),
        .bus           (bus_b)
    );

    task automatic chk(input string nm, input int act, input int exp);
        nchk++;
        if (act != exp) begin
            nerr++;
            $display("FAIL %s: got %0d, expected %0d at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic step();
        @(negedge clk);
        #1;
    endtask

    task automatic wait_idle(input int bound);
        for (int i = 0; i < bound && bsy[0]; i++) step();
        chk("idle_reached", bsy[0], 0);
    endtask

    // Frame model: phase 0 idle, 1 ack, 2 start, 3 wait, 4 stream.
    int np[2] = '{NA, NB};
    int m_ph[2] = '{0, 0};
    int m_idx[2] = '{0, 0};

    always @(posedge clk or negedge rst_n) begin
        for (int k = 0; k < 2; k++) begin
            if (!rst_n) begin
                m_ph[k] <= 0;
                m_idx[k] <= 0;
            end else if (m_ph[k] == 0) begin
                if (rdn) m_ph[k] <= 1;
            end else if (m_ph[k] < 3) begin
                m_ph[k] <= m_ph[k] + 1;
            end else if (m_ph[k] == 3) begin
                if (rot_done) m_ph[k] <= 4;
                m_idx[k] <= 0;
            end else if (bcau) begin
                if (m_idx[k] == np[k] - 1) begin
                    m_ph[k] <= 0;
                    m_idx[k] <= 0;
                end else begin
                    m_idx[k] <= m_idx[k] + 1;
                end
            end
        end
    end

    always @(negedge clk) begin
        int pv[2];
        int pi[2];
        int pl[2];
        pv = '{int'(bus_a.out_valid), int'(bus_b.out_valid)};
        pi = '{int'(bus_a.pix_idx), int'(bus_b.pix_idx)};
        pl = '{int'(bus_a.out_last), int'(bus_b.out_last)};
        for (int k = 0; k < 2; k++) begin
            chk($sformatf("m%0d_ack", k), ack[k], m_ph[k] == 1);
            chk($sformatf("m%0d_cap", k), cap[k], m_ph[k] == 1);
            chk($sformatf("m%0d_start", k), srt[k], m_ph[k] == 2);
            chk($sformatf("m%0d_busy", k), bsy[k], m_ph[k] != 0);
            chk($sformatf("m%0d_valid", k), pv[k], m_ph[k] == 4);
            chk($sformatf("m%0d_idx", k), pi[k], m_idx[k]);
            chk($sformatf("m%0d_last", k), pl[k],
                (m_ph[k] == 4) && (m_idx[k] == np[k] - 1));
        end
    end

    typedef struct {
        logic rdn, rd, b;
        logic ack, start, valid, busy;
        int   idx;
    } vec_t;

    initial begin
        vec_t tbl[8];
        int   hs;
        int   vc;
        int   acks;
        tbl[0] = '{1, 0, 0, 1, 0, 0, 1, 0};
        tbl[1] = '{0, 1, 0, 0, 1, 0, 1, 0};
        tbl[2] = '{0, 1, 0, 0, 0, 0, 1, 0};
        tbl[3] = '{0, 0, 0, 0, 0, 0, 1, 0};
        tbl[4] = '{0, 1, 0, 0, 0, 1, 1, 0};
        tbl[5] = '{0, 0, 1, 0, 0, 1, 1, 1};
        tbl[6] = '{0, 0, 0, 0, 0, 1, 1, 1};
        tbl[7] = '{0, 0, 1, 0, 0, 1, 1, 2};

        // Reset held with all inputs high: nothing may happen.
        rdn = 1; rot_done = 1; bcau = 1;
        repeat (3) step();
        chk("rst_busy", bsy[0], 0);
        chk("rst_ack", ack[0], 0);
        chk("rst_valid", bus_a.out_valid, 0);
        rdn = 0; rot_done = 0; bcau = 0;
        rst_n = 1;
        step();

        for (int i = 0; i < 8; i++) begin
            rdn = tbl[i].rdn; rot_done = tbl[i].rd; bcau = tbl[i].b;
            step();
            chk($sformatf("tbl%0d_ack", i), ack[0], tbl[i].ack);
            chk($sformatf("tbl%0d_start", i), srt[0], tbl[i].start);
            chk($sformatf("tbl%0d_valid", i), bus_a.out_valid, tbl[i].valid);
            chk($sformatf("tbl%0d_busy", i), bsy[0], tbl[i].busy);
            chk($sformatf("tbl%0d_idx", i), int'(bus_a.pix_idx), tbl[i].idx);
        end
        rdn = 0; rot_done = 0; bcau = 1;
        wait_idle(1000);

        // Nominal frame: ready at cycle 0, rot_done at cycle 5.
        for (int c = 0; c < 410; c++) begin
            int t;
            rdn = (c == 0); rot_done = (c == 5); bcau = 1;
            step();
            t = c + 1;
            chk("nom_ack", ack[0], t == 1);
            chk("nom_start", srt[0], t == 2);
            chk("nom_valid", bus_a.out_valid, t >= 6 && t <= 405);
            chk("nom_busy", bsy[0], t >= 1 && t <= 405);
            chk("nom_last", bus_a.out_last, t == 405);
            if (t >= 6 && t <= 405) chk("nom_idx", int'(bus_a.pix_idx), t - 6);
        end

        // Backpressure: ready on alternate cycles.
        hs = 0; vc = 0;
        for (int c = 0; c < 806; c++) begin
            rdn = (c == 0); rot_done = (c == 3); bcau = (c % 2 == 0);
            if (bus_a.out_valid) vc++;
            if (bus_a.out_valid && bcau) hs++;
            step();
        end
        chk("bp_transfers", hs, 400);
        chk("bp_valid_cycles", vc, 799);
        chk("bp_idle", bsy[0], 0);

        // RDN ready stuck high: one acknowledge per frame.
        rdn = 1; rot_done = 1; bcau = 1;
        acks = 0;
        for (int i = 0; i < 1000; i++) begin
            step();
            if (!bsy[0]) break;
            if (ack[0]) acks++;
        end
        chk("stray_acks", acks, 1);
        chk("stray_idle", bsy[0], 0);
        step();
        chk("stray_next_ack", ack[0], 1);
        rdn = 0;
        wait_idle(1000);

        // Random traffic against the model.
        for (int i = 0; i < 4000; i++) begin
            rdn = ($urandom_range(0, 7) == 0);
            rot_done = ($urandom_range(0, 3) == 0);
            bcau = 1'($urandom_range(0, 1));
            step();
        end

        // Reset mid-stream at pixel 123.
        rdn = 0; rot_done = 0; bcau = 1;
        wait_idle(2000);
        rdn = 1;
        step();
        rdn = 0; rot_done = 1;
        for (int i = 0; i < 1000; i++) begin
            if (bus_a.out_valid && bus_a.pix_idx == WA'(123)) break;
            step();
        end
        chk("mid_reached", int'(bus_a.pix_idx), 123);
        rst_n = 0;
        #1;
        chk("mid_rst_valid", bus_a.out_valid, 0);
        chk("mid_rst_idx", int'(bus_a.pix_idx), 0);
        chk("mid_rst_busy", bsy[0], 0);
        rdn = 0; rot_done = 0; bcau = 0;
        step();
        step();
        rst_n = 1;
        step();
        rdn = 1;
        step();
        rdn = 0; rot_done = 1;
        repeat (3) step();
        chk("post_rst_valid", bus_a.out_valid, 1);
        chk("post_rst_idx", int'(bus_a.pix_idx), 0);
        rot_done = 0; bcau = 1;
        wait_idle(1000);

        $display("End of test - %0d assertions evaluated, %0d failures", nchk, nerr);
        $finish;
    end
endmodule
